// File: rtl/lfsr_gen.sv
// lfsr_gen: Fibonacci LFSR pattern generator with seed load, lock-up recovery and wrap strobe.
// Define LFSR_PERIOD_CNT_EN to add the step_cnt/period_len period measurement outputs.
module lfsr_gen #(
    parameter int WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS = 4'b1100,
    parameter logic [WIDTH-1:0] SEED = 4'b0001
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] Q,
    output logic             serial_out,
    output logic             wrap,
    output logic             lock_err
`ifdef LFSR_PERIOD_CNT_EN
    ,
    output logic [WIDTH-1:0] step_cnt,
    output logic [WIDTH-1:0] period_len
`endif
);
    generate
        if (SEED == '0 || WIDTH < 2) begin : g_bad_param
            $error("lfsr_gen: SEED must be non-zero and WIDTH >= 2");
        end
    endgenerate

    logic [WIDTH-1:0] active_seed;
    logic [WIDTH-1:0] nxt;
    logic             zero_seed;
    logic             lock_step;

    assign nxt        = {Q[WIDTH-2:0], ^(Q & TAPS)};
    assign zero_seed  = seed_in == '0;
    assign lock_step  = Q == '0;
    assign serial_out = Q[WIDTH-1];

    always_ff @(posedge clock) begin
        if (reset) begin
            Q           <= SEED;
            active_seed <= SEED;
            wrap        <= 1'b0;
            lock_err    <= 1'b0;
        end else if (load) begin
            Q           <= zero_seed ? SEED : seed_in;
            active_seed <= zero_seed ? SEED : seed_in;
            wrap        <= 1'b0;
            lock_err    <= zero_seed;
        end else if (enable) begin
            Q        <= lock_step ? SEED : nxt;
            wrap     <= !lock_step && (nxt == active_seed);
            lock_err <= lock_step;
        end else begin
            wrap     <= 1'b0;
            lock_err <= 1'b0;
        end
    end

`ifdef LFSR_PERIOD_CNT_EN
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // A wrap step closes the period: its length includes the wrapping step itself.
    always_ff @(posedge clock) begin
        if (reset) begin
            step_cnt   <= '0;
            period_len <= '0;
        end else if (load || (enable && lock_step)) begin
            step_cnt <= '0;
        end else if (enable && nxt == active_seed) begin
            period_len <= step_cnt + ONE;
            step_cnt   <= '0;
        end else if (enable) begin
            step_cnt <= step_cnt + ONE;
        end
    end
`endif
endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: directed and randomized checks of lfsr_gen against an arithmetic reference model.
module tb_lfsr_gen;
    localparam int W = 4;
    localparam int MOD = 16;
    localparam int TAPS_I = 12;
    localparam int SEED_I = 1;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         enable = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] seed_in = '0;
    logic [W-1:0] Q;
    logic         serial_out;
    logic         wrap;
    logic         lock_err;
`ifdef LFSR_PERIOD_CNT_EN
    logic [W-1:0] step_cnt;
    logic [W-1:0] period_len;
`endif

    lfsr_gen #(.WIDTH(W), .TAPS(4'b1100), .SEED(4'b0001)) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .load(load),
        .seed_in(seed_in),
        .Q(Q),
        .serial_out(serial_out),
        .wrap(wrap),
        .lock_err(lock_err)
`ifdef LFSR_PERIOD_CNT_EN
        ,
        .step_cnt(step_cnt),
        .period_len(period_len)
`endif
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;
    int m_q = SEED_I, m_seed = SEED_I, m_wrap = 0, m_lock = 0, m_cnt = 0, m_plen = 0;
    int wrap_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Feedback parity counted bit by bit, then shifted in with plain arithmetic.
    function automatic int model_next(input int q);
        int ones = 0;
        for (int i = 0; i < W; i++) if (((q & TAPS_I) >> i) % 2 == 1) ones++;
        return (q * 2 + ones % 2) % MOD;
    endfunction

    task automatic model_step(input int r, input int en, input int ld, input int sd);
        int nx;
        if (r != 0) begin
            m_q = SEED_I; m_seed = SEED_I; m_wrap = 0; m_lock = 0; m_cnt = 0; m_plen = 0;
        end else if (ld != 0) begin
            m_q = (sd == 0) ? SEED_I : sd;
            m_seed = m_q; m_wrap = 0; m_lock = (sd == 0); m_cnt = 0;
        end else if (en != 0) begin
            if (m_q == 0) begin
                m_q = SEED_I; m_lock = 1; m_wrap = 0; m_cnt = 0;
            end else begin
                nx = model_next(m_q);
                m_wrap = (nx == m_seed); m_lock = 0; m_q = nx;
                if (m_wrap != 0) begin m_plen = (m_cnt + 1) % MOD; m_cnt = 0; end
                else m_cnt = (m_cnt + 1) % MOD;
            end
        end else begin
            m_wrap = 0; m_lock = 0;
        end
    endtask

    task automatic cyc(input int r, input int en, input int ld, input int sd);
        reset = r[0]; enable = en[0]; load = ld[0]; seed_in = sd[W-1:0];
        @(posedge clock);
        #1;
        model_step(r, en, ld, sd);
        if (wrap === 1'b1) wrap_seen++;
        chk("Q", 32'(Q), 32'(m_q));
        chk("serial_out", 32'(serial_out), 32'(m_q / 8));
        chk("wrap", 32'(wrap), 32'(m_wrap));
        chk("lock_err", 32'(lock_err), 32'(m_lock));
`ifdef LFSR_PERIOD_CNT_EN
        chk("step_cnt", 32'(step_cnt), 32'(m_cnt));
        chk("period_len", 32'(period_len), 32'(m_plen));
`endif
    endtask

    int exp_seq[15] = '{2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8, 1};

    initial begin
        // Reset for two edges, then idle.
        cyc(1, 1, 1, 5);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("reset_Q_const", 32'(Q), 32'd1);
        chk("reset_serial_const", 32'(serial_out), 32'd0);

        // Full maximal-length period from 0001 with the published sequence.
        for (int i = 0; i < 15; i++) begin
            cyc(0, 1, 0, 0);
            chk("seq_const", 32'(Q), 32'(exp_seq[i]));
            chk("seq_wrap_const", 32'(wrap), 32'(i == 14));
        end

        // Load takes priority over enable, then wrap on return to loaded seed.
        cyc(0, 1, 1, 11);
        chk("load_Q_const", 32'(Q), 32'd11);
        wrap_seen = 0;
        for (int i = 0; i < 15; i++) cyc(0, 1, 0, 0);
        chk("load_wrap_count", 32'(wrap_seen), 32'd1);
        chk("load_return_const", 32'(Q), 32'd11);

        // Zero seed falls back to SEED with a single-cycle lock_err pulse.
        cyc(0, 0, 1, 0);
        chk("zero_load_Q", 32'(Q), 32'd1);
        chk("zero_load_lock", 32'(lock_err), 32'd1);
        cyc(0, 0, 0, 0);
        chk("lock_clears", 32'(lock_err), 32'd0);

        // Enable gaps stretch time but not step count.
        wrap_seen = 0;
        for (int i = 0; i < 30; i++) cyc(0, (i % 2 == 0) ? 1 : 0, 0, 0);
        chk("gap_wrap_count", 32'(wrap_seen), 32'd1);
        chk("gap_Q_const", 32'(Q), 32'd1);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(1, 1, 0, 0);
        chk("mid_reset_Q", 32'(Q), 32'd1);

`ifdef LFSR_PERIOD_CNT_EN
        for (int i = 0; i < 15; i++) cyc(0, 1, 0, 0);
        chk("period_len_const", 32'(period_len), 32'd15);
        chk("step_cnt_const", 32'(step_cnt), 32'd0);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            int r, ld, en, sd;
            r  = ($urandom_range(0, 49) == 0) ? 1 : 0;
            ld = ($urandom_range(0, 19) == 0) ? 1 : 0;
            en = ($urandom_range(0, 3) != 0) ? 1 : 0;
            sd = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, MOD - 1));
            cyc(r, en, ld, sd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
